// File: rtl/config_pkg.sv
// config_pkg
// Shared floating-point configuration: register width, format-code width,
// the format encodings and the per-format total/exponent/fraction widths.
// No ports; imported by the sign-injection lane and its pipeline wrapper.
package config_pkg;

    localparam int FLEN    = 64;
    localparam int FMTBITS = 2;

    localparam logic [FMTBITS-1:0] S_FMT = 2'b00;
    localparam logic [FMTBITS-1:0] D_FMT = 2'b01;
    localparam logic [FMTBITS-1:0] H_FMT = 2'b10;
    localparam logic [FMTBITS-1:0] Q_FMT = 2'b11;

    localparam int S_LEN = 32;
    localparam int S_NE  = 8;
    localparam int S_NF  = 23;
    localparam int D_LEN = 64;
    localparam int D_NE  = 11;
    localparam int D_NF  = 52;
    localparam int H_LEN = 16;
    localparam int H_NE  = 5;
    localparam int H_NF  = 10;
    localparam int Q_LEN = 128;
    localparam int Q_NE  = 15;
    localparam int Q_NF  = 112;

endpackage

// File: rtl/fsgninj_lane.sv
// fsgninj_lane
// One lane of FP sign injection, split into two purely combinational halves
// so the wrapper can place a register between them.
// Front half (fmt, op, x, y -> x_eff, sgn, err):
//   checks NaN-boxing of both operands, substitutes the canonical NaN for an
//   unboxed x, and computes the injected sign. x_eff holds only the format
//   bits (bits above the format width are zero).
// Back half (asm_fmt, asm_x, asm_sgn -> res):
//   assembles the NaN-boxed result from a front-half x_eff and sign.
module fsgninj_lane #(
    parameter int FLEN    = config_pkg::FLEN,
    parameter int FMTBITS = config_pkg::FMTBITS
) (
    input  logic [FMTBITS-1:0] fmt,
    input  logic [1:0]         op,
    input  logic [FLEN-1:0]    x,
    input  logic [FLEN-1:0]    y,
    output logic [FLEN-1:0]    x_eff,
    output logic               sgn,
    output logic               err,
    input  logic [FMTBITS-1:0] asm_fmt,
    input  logic [FLEN-1:0]    asm_x,
    input  logic               asm_sgn,
    output logic [FLEN-1:0]    res
);
    import config_pkg::*;

    localparam logic [FLEN-1:0] ONES = '1;
    localparam logic [FLEN-1:0] LSB  = {{(FLEN-1){1'b0}}, 1'b1};

    // Quad only fits when the register is wide enough; otherwise the widest
    // format the register holds (double) is used so the decode stays sane.
    function automatic int fmt_len(input logic [FMTBITS-1:0] f);
        case (f)
            S_FMT:   return (S_LEN <= FLEN) ? S_LEN : FLEN;
            D_FMT:   return (D_LEN <= FLEN) ? D_LEN : FLEN;
            H_FMT:   return (H_LEN <= FLEN) ? H_LEN : FLEN;
            default: return (Q_LEN <= FLEN) ? Q_LEN : FLEN;
        endcase
    endfunction

    function automatic int fmt_ne(input logic [FMTBITS-1:0] f);
        case (f)
            S_FMT:   return S_NE;
            D_FMT:   return D_NE;
            H_FMT:   return H_NE;
            default: return (Q_LEN <= FLEN) ? Q_NE : D_NE;
        endcase
    endfunction

    function automatic int fmt_nf(input logic [FMTBITS-1:0] f);
        case (f)
            S_FMT:   return S_NF;
            D_FMT:   return D_NF;
            H_FMT:   return H_NF;
            default: return (Q_LEN <= FLEN) ? Q_NF : D_NF;
        endcase
    endfunction

    logic [FLEN-1:0] upper;
    logic [FLEN-1:0] sign_bit;
    logic [FLEN-1:0] canon_nan;
    logic            x_boxed;
    logic            y_boxed;
    logic            xs;
    logic            ys;

    // upper masks the bits above the format width (all zero for the full
    // width format, since a shift by the full width yields zero). The
    // canonical NaN is NE+1 ones starting at the fraction MSB.
    always_comb begin
        upper     = ONES << fmt_len(fmt);
        sign_bit  = LSB << (fmt_len(fmt) - 1);
        canon_nan = (ONES >> (FLEN - (fmt_ne(fmt) + 1))) << (fmt_nf(fmt) - 1);
        x_boxed   = ((x & upper) == upper);
        y_boxed   = ((y & upper) == upper);
        x_eff     = x_boxed ? (x & ~upper) : canon_nan;
        xs        = |(x_eff & sign_bit);
        ys        = y_boxed & (|(y & sign_bit));
        err       = ~(x_boxed & y_boxed);
        case (op)
            2'b01:   sgn = ~ys;
            2'b10:   sgn = xs ^ ys;
            default: sgn = ys;
        endcase
    end

    logic [FLEN-1:0] asm_upper;
    logic [FLEN-1:0] asm_sign_bit;

    // Fill above the format with ones, drop in the injected sign, keep the
    // remaining format bits of x.
    always_comb begin
        asm_upper    = ONES << fmt_len(asm_fmt);
        asm_sign_bit = LSB << (fmt_len(asm_fmt) - 1);
        res          = asm_upper | (asm_x & ~asm_upper & ~asm_sign_bit)
                     | (asm_sgn ? asm_sign_bit : '0);
    end

endmodule

// File: rtl/fsgninj_lanes.sv
// fsgninj_lanes
// NLANES parallel FP sign-injection lanes behind a shared valid/ready
// pipeline of STAGES (1 or 2) single-entry stages.
// Ports:
//   clk, reset_n           clock, synchronous active-low reset
//   InValid/InReady        input handshake; X, Y (per-lane operands),
//                          Fmt, OpCtrl, InTag travel with it
//   Flush                  drops everything in flight and the concurrent input
//   OutValid/OutReady      output handshake; SgnRes, OutTag, BoxErr travel
//                          with it and hold while stalled
module fsgninj_lanes #(
    parameter int FLEN    = config_pkg::FLEN,
    parameter int FMTBITS = config_pkg::FMTBITS,
    parameter int NLANES  = 1,
    parameter int STAGES  = 2,
    parameter int TAGW    = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   InValid,
    output logic                   InReady,
    input  logic [NLANES*FLEN-1:0] X,
    input  logic [NLANES*FLEN-1:0] Y,
    input  logic [FMTBITS-1:0]     Fmt,
    input  logic [1:0]             OpCtrl,
    input  logic [TAGW-1:0]        InTag,
    input  logic                   Flush,
    output logic                   OutValid,
    input  logic                   OutReady,
    output logic [NLANES*FLEN-1:0] SgnRes,
    output logic [TAGW-1:0]        OutTag,
    output logic [NLANES-1:0]      BoxErr
);
    logic [NLANES*FLEN-1:0] front_x;
    logic [NLANES-1:0]      front_sgn;
    logic [NLANES-1:0]      front_err;
    logic [FMTBITS-1:0]     asm_fmt;
    logic [NLANES*FLEN-1:0] asm_x;
    logic [NLANES-1:0]      asm_sgn;
    logic [NLANES*FLEN-1:0] lane_res;

    for (genvar i = 0; i < NLANES; i++) begin : g_lane
        fsgninj_lane #(.FLEN(FLEN), .FMTBITS(FMTBITS)) u_lane (
            .fmt     (Fmt),
            .op      (OpCtrl),
            .x       (X[i*FLEN +: FLEN]),
            .y       (Y[i*FLEN +: FLEN]),
            .x_eff   (front_x[i*FLEN +: FLEN]),
            .sgn     (front_sgn[i]),
            .err     (front_err[i]),
            .asm_fmt (asm_fmt),
            .asm_x   (asm_x[i*FLEN +: FLEN]),
            .asm_sgn (asm_sgn[i]),
            .res     (lane_res[i*FLEN +: FLEN])
        );
    end

    logic out_free;

    // Output stage can take a new entry when empty or being consumed.
    assign out_free = ~OutValid | OutReady;

    if (STAGES == 2) begin : g_two
        logic                   s1_valid;
        logic [NLANES*FLEN-1:0] s1_x;
        logic [NLANES-1:0]      s1_sgn;
        logic [NLANES-1:0]      s1_err;
        logic [FMTBITS-1:0]     s1_fmt;
        logic [TAGW-1:0]        s1_tag;

        assign asm_fmt = s1_fmt;
        assign asm_x   = s1_x;
        assign asm_sgn = s1_sgn;
        assign InReady = ~s1_valid | out_free;

        // Stage 1 holds unbox results and signs; stage 2 the assembled
        // result. Flush only clears valid bits; stale data is harmless.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                s1_valid <= 1'b0;
                s1_x     <= '0;
                s1_sgn   <= '0;
                s1_err   <= '0;
                s1_fmt   <= '0;
                s1_tag   <= '0;
                OutValid <= 1'b0;
                SgnRes   <= '0;
                OutTag   <= '0;
                BoxErr   <= '0;
            end else begin
                if (Flush) begin
                    s1_valid <= 1'b0;
                    OutValid <= 1'b0;
                end else begin
                    if (out_free) OutValid <= s1_valid;
                    if (InReady)  s1_valid <= InValid;
                end
                if (out_free && s1_valid) begin
                    SgnRes <= lane_res;
                    OutTag <= s1_tag;
                    BoxErr <= s1_err;
                end
                if (InReady && InValid) begin
                    s1_x   <= front_x;
                    s1_sgn <= front_sgn;
                    s1_err <= front_err;
                    s1_fmt <= Fmt;
                    s1_tag <= InTag;
                end
            end
        end
    end else begin : g_one
        assign asm_fmt = Fmt;
        assign asm_x   = front_x;
        assign asm_sgn = front_sgn;
        assign InReady = out_free;

        // Single stage: the fully assembled result is registered directly.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                OutValid <= 1'b0;
                SgnRes   <= '0;
                OutTag   <= '0;
                BoxErr   <= '0;
            end else begin
                if (Flush) OutValid <= 1'b0;
                else if (out_free) OutValid <= InValid;
                if (out_free && InValid) begin
                    SgnRes <= lane_res;
                    OutTag <= InTag;
                    BoxErr <= front_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_fsgninj_lanes.sv
// tb_fsgninj_lanes
// Four-lane, two-stage instance. Stimulus pushes hand-computed expected
// results into a scoreboard queue; an independent monitor pops and compares
// on every output transfer.
module tb_fsgninj_lanes;

    localparam int NL   = 4;
    localparam int FL   = 64;
    localparam int TAGW = 4;
    localparam int W    = NL * FL;

    localparam logic [1:0] S_F = 2'b00;
    localparam logic [1:0] D_F = 2'b01;
    localparam logic [1:0] H_F = 2'b10;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            InValid;
    logic            InReady;
    logic [W-1:0]    X;
    logic [W-1:0]    Y;
    logic [1:0]      Fmt;
    logic [1:0]      OpCtrl;
    logic [TAGW-1:0] InTag;
    logic            Flush;
    logic            OutValid;
    logic            OutReady;
    logic [W-1:0]    SgnRes;
    logic [TAGW-1:0] OutTag;
    logic [NL-1:0]   BoxErr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [TAGW-1:0] tag;
        logic [W-1:0]    res;
        logic [NL-1:0]   err;
    } exp_t;

    exp_t sbq[$];

    fsgninj_lanes #(.NLANES(NL), .STAGES(2), .TAGW(TAGW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .InValid  (InValid),
        .InReady  (InReady),
        .X        (X),
        .Y        (Y),
        .Fmt      (Fmt),
        .OpCtrl   (OpCtrl),
        .InTag    (InTag),
        .Flush    (Flush),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .SgnRes   (SgnRes),
        .OutTag   (OutTag),
        .BoxErr   (BoxErr)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] rep4(input logic [63:0] v);
        return {v, v, v, v};
    endfunction

    task automatic checkOutput(input string name, input logic [W-1:0] act,
                               input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Holds the offer until accepted (InReady sampled on the falling edge),
    // queueing the expectation when push is set.
    task automatic applyStimulus(input logic [TAGW-1:0] tag, input logic [1:0] fmt,
                                 input logic [1:0] op, input logic [W-1:0] x,
                                 input logic [W-1:0] y, input logic [W-1:0] er,
                                 input logic [NL-1:0] ee, input bit push);
        bit accepted = 0;
        exp_t e;
        InValid = 1'b1;
        InTag   = tag;
        Fmt     = fmt;
        OpCtrl  = op;
        X       = x;
        Y       = y;
        for (int n = 0; n < 100 && !accepted; n++) begin
            @(negedge clk);
            if (InReady) begin
                accepted = 1;
                if (push) begin
                    e.tag = tag;
                    e.res = er;
                    e.err = ee;
                    sbq.push_back(e);
                end
            end
            @(posedge clk);
            #1;
        end
        InValid = 1'b0;
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: tag %0d never accepted", tag);
        end
    endtask

    task automatic waitDrain();
        for (int n = 0; n < 200 && sbq.size() != 0; n++) @(negedge clk);
        @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", W'(sbq.size()), '0);
    endtask

    // Monitor: every output transfer must match the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset_n && OutValid && OutReady) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output: got tag %0d, expected none", OutTag);
            end else begin
                e = sbq.pop_front();
                checkOutput("out_tag", W'(OutTag), W'(e.tag));
                checkOutput("sgn_res", SgnRes, e.res);
                checkOutput("box_err", W'(BoxErr), W'(e.err));
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset_n  = 1'b0;
        InValid  = 1'b0;
        X        = '0;
        Y        = '0;
        Fmt      = S_F;
        OpCtrl   = 2'b00;
        InTag    = '0;
        Flush    = 1'b0;
        OutReady = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_inready", W'(InReady), W'(1));
        checkOutput("rst_outvalid", W'(OutValid), '0);
        checkOutput("rst_sgnres", SgnRes, '0);
        checkOutput("rst_outtag", W'(OutTag), '0);
        checkOutput("rst_boxerr", W'(BoxErr), '0);
        @(posedge clk);
        #1;

        // S fsgnj with exact latency check
        applyStimulus(4'd1, S_F, 2'b00, rep4(64'hFFFFFFFF_3F800000),
                      rep4(64'hFFFFFFFF_BF800000), rep4(64'hFFFFFFFF_BF800000), 4'b0000, 1);
        @(negedge clk);
        checkOutput("latency_early", W'(OutValid), '0);
        @(negedge clk);
        checkOutput("latency_exact", W'(OutValid), W'(1));
        @(posedge clk);
        #1;

        // Back-to-back function vectors
        applyStimulus(4'd2, S_F, 2'b01, rep4(64'h00000000_3F800000),
                      rep4(64'hFFFFFFFF_3F800000), rep4(64'hFFFFFFFF_FFC00000), 4'b1111, 1);
        applyStimulus(4'd3, D_F, 2'b10, rep4(64'hC000000000000000),
                      rep4(64'h8000000000000000), rep4(64'h4000000000000000), 4'b0000, 1);
        applyStimulus(4'd4, H_F, 2'b00, rep4(64'hFFFFFFFFFFFF3C00),
                      rep4(64'hFFFFFFFFFFFF8000), rep4(64'hFFFFFFFFFFFFBC00), 4'b0000, 1);
        applyStimulus(4'd5, S_F, 2'b11, rep4(64'hFFFFFFFF_BF800000),
                      rep4(64'hFFFFFFFF_3F800000), rep4(64'hFFFFFFFF_3F800000), 4'b0000, 1);
        applyStimulus(4'd6, S_F, 2'b01, rep4(64'hFFFFFFFF_3F800000),
                      rep4(64'h00000000_BF800000), rep4(64'hFFFFFFFF_BF800000), 4'b1111, 1);
        waitDrain();

        // Backpressure: two buffered, third refused, then in-order release
        OutReady = 1'b0;
        for (int t = 1; t <= 2; t++)
            applyStimulus(TAGW'(t), S_F, 2'b00, rep4(64'hFFFFFFFF_3F800000),
                          rep4(64'hFFFFFFFF_BF800000), rep4(64'hFFFFFFFF_BF800000), 4'b0000, 1);
        InValid = 1'b1;
        InTag   = 4'd3;
        @(negedge clk);
        checkOutput("bp_inready_low", W'(InReady), '0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("bp_inready_still_low", W'(InReady), '0);
        checkOutput("bp_hold_tag", W'(OutTag), W'(1));
        checkOutput("bp_hold_res", SgnRes, rep4(64'hFFFFFFFF_BF800000));
        @(posedge clk);
        #1;
        OutReady = 1'b1;
        for (int t = 3; t <= 4; t++)
            applyStimulus(TAGW'(t), S_F, 2'b00, rep4(64'hFFFFFFFF_3F800000),
                          rep4(64'hFFFFFFFF_BF800000), rep4(64'hFFFFFFFF_BF800000), 4'b0000, 1);
        waitDrain();

        // Flush: two in flight plus a concurrent offer, none may emerge
        OutReady = 1'b0;
        applyStimulus(4'd7, S_F, 2'b00, rep4(64'hFFFFFFFF_3F800000),
                      rep4(64'hFFFFFFFF_3F800000), '0, '0, 0);
        applyStimulus(4'd8, S_F, 2'b00, rep4(64'hFFFFFFFF_3F800000),
                      rep4(64'hFFFFFFFF_3F800000), '0, '0, 0);
        InValid = 1'b1;
        InTag   = 4'd9;
        Flush   = 1'b1;
        @(negedge clk);
        checkOutput("flush_inready_normal", W'(InReady), '0);
        @(posedge clk);
        #1;
        Flush   = 1'b0;
        InValid = 1'b0;
        @(negedge clk);
        checkOutput("flush_outvalid", W'(OutValid), '0);
        checkOutput("flush_inready", W'(InReady), W'(1));
        OutReady = 1'b1;
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1;
        applyStimulus(4'd10, D_F, 2'b01, rep4(64'h3FF0000000000000),
                      rep4(64'h3FF0000000000000), rep4(64'hBFF0000000000000), 4'b0000, 1);
        waitDrain();

        // Mid-stream reset for one cycle
        OutReady = 1'b0;
        applyStimulus(4'd11, S_F, 2'b00, rep4(64'hFFFFFFFF_3F800000),
                      rep4(64'hFFFFFFFF_BF800000), '0, '0, 0);
        applyStimulus(4'd12, S_F, 2'b00, rep4(64'hFFFFFFFF_3F800000),
                      rep4(64'hFFFFFFFF_BF800000), '0, '0, 0);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("mrst_outvalid", W'(OutValid), '0);
        checkOutput("mrst_sgnres", SgnRes, '0);
        checkOutput("mrst_outtag", W'(OutTag), '0);
        checkOutput("mrst_boxerr", W'(BoxErr), '0);
        checkOutput("mrst_inready", W'(InReady), W'(1));
        OutReady = 1'b1;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;

        // Independent lanes mixing boxed and unboxed operands
        applyStimulus(4'd13, S_F, 2'b00,
                      {64'hFFFFFFFF_C0000000, 64'hFFFFFFFF_40490FDB,
                       64'h12345678_3F800000, 64'hFFFFFFFF_3F800000},
                      {64'hFFFFFFFF_00000000, 64'h7FFFFFFF_80000000,
                       64'hFFFFFFFF_BF800000, 64'hFFFFFFFF_BF800000},
                      {64'hFFFFFFFF_40000000, 64'hFFFFFFFF_40490FDB,
                       64'hFFFFFFFF_FFC00000, 64'hFFFFFFFF_BF800000},
                      4'b0110, 1);
        waitDrain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
